uart_tx_arb: RTL and testbench

Round-robin arbiter and sequencer that shares a single `uart_tx` transmitter between `NUM_REQ` byte producers (CPU core, debug monitor, trace unit, ...). Each requester offers bytes over a valid/ready handshake. The arbiter picks a winner, drives the transmitter's `start`/`data_in` for exactly one cycle, and tracks `busy` to the end of the frame. A per-requester `last` flag keeps the grant locked for multi-byte packets, so messages from different sources never interleave.

---
 rtl/uart_tx_arb.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte producers.
// A packet (bytes up to and including req_last) keeps the grant locked until it completes.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for an eligible valid with uart_busy low; accepts the byte
// S_ISSUE     | byte latched in data_q; uart_start is registered for the next cycle
// S_WAIT_BUSY | start pulse out, timer running until uart_busy rises
// S_WAIT_DONE | frame in progress, waiting for uart_busy to fall
module uart_tx_arb #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   uart_start,
    output logic [7:0]             uart_data,
    input  logic                   uart_busy,
    output logic [2:0]             grant_id,
    output logic                   locked,
    output logic                   err_timeout
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         rr_ptr;
    logic [7:0]         data_q;
    logic [TW-1:0]      tmr;

    logic [7:0]         valid_ext;
    logic [7:0]         last_ext;
    logic [7:0]         elig;
    logic [3:0]         idx;
    logic               win_found;
    logic [2:0]         win_id;
    logic [7:0]         win_data;
    logic               win_last;
    logic [NUM_REQ-1:0] win_onehot;

    logic               accept;
    logic               issue;
    logic               tmr_expired;
    logic               timeout_hit;

    // Widen to 8 lanes so every index below is a plain 3-bit select.
    always_comb begin
        valid_ext = 8'(req_valid);
        last_ext  = 8'(req_last);
        elig      = locked ? (valid_ext & (8'b1 << grant_id)) : valid_ext;
        win_found = 1'b0;
        win_id    = 3'd0;
        idx       = 4'd0;
        // Scan farthest offset first so the lowest offset from rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + 4'(k);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (elig[idx[2:0]]) begin
                win_found = 1'b1;
                win_id    = idx[2:0];
            end
        end
    end

    always_comb begin
        win_data   = 8'd0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == 3'(i)) begin
                win_data      = req_data[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
        win_last = last_ext[win_id];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (win_found && !uart_busy) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmr_expired) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        accept      = (state == S_IDLE) && win_found && !uart_busy;
        issue       = (state == S_ISSUE);
        tmr_expired = (tmr == '0);
        timeout_hit = (state == S_WAIT_BUSY) && !uart_busy && tmr_expired;
    end

    // Every output is a flop: ready shows during ISSUE, start one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready   <= '0;
            uart_start  <= 1'b0;
            data_q      <= 8'd0;
            grant_id    <= 3'd0;
            locked      <= 1'b0;
            rr_ptr      <= 3'd0;
            err_timeout <= 1'b0;
            tmr         <= '0;
        end else begin
            req_ready  <= '0;
            uart_start <= issue;
            if (accept) begin
                req_ready <= win_onehot;
                data_q    <= win_data;
                grant_id  <= win_id;
                locked    <= !win_last;
                if (win_last) begin
                    rr_ptr <= (win_id == 3'(NUM_REQ - 1)) ? 3'd0 : win_id + 3'd1;
                end
            end
            if (issue) begin
                tmr <= TW'(BUSY_TIMEOUT - 1);
            end else if ((state == S_WAIT_BUSY) && !tmr_expired) begin
                tmr <= tmr - TW'(1);
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
                locked      <= 1'b0;
            end
        end
    end

    assign uart_data = data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: behavioural uart_tx busy model that records each
// transmitted byte, a table of single-byte grants and hand sequences for the corner cases.
module tb_uart_tx_arb;

    localparam int NR    = 4;
    localparam int BT    = 15;
    localparam int FRAME = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0] req_last = '0;
    logic [NR-1:0] req_ready;
    logic          uart_start;
    logic [7:0]    uart_data;
    logic          uart_busy;
    logic [2:0]    grant_id;
    logic          locked;
    logic          err_timeout;

    logic          tie_low = 1'b0;
    int            bcnt;
    logic [7:0]    sh;
    logic [7:0]    rx_q[$];
    logic          prev_start = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_start(uart_start),
        .uart_data(uart_data), .uart_busy(uart_busy), .grant_id(grant_id),
        .locked(locked), .err_timeout(err_timeout)
    );

    // uart_tx stand-in: busy rises the cycle after start and lasts one 10-bit frame.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_busy <= 1'b0;
            bcnt      <= 0;
        end else if (!uart_busy) begin
            if (uart_start && !tie_low) begin
                uart_busy <= 1'b1;
                bcnt      <= FRAME - 1;
                sh        <= uart_data;
            end
        end else if (bcnt == 0) begin
            uart_busy <= 1'b0;
            rx_q.push_back(sh);
        end else begin
            bcnt <= bcnt - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
            chk("start_while_busy", 32'(uart_start & uart_busy), 0);
            chk("start_width", 32'(uart_start & prev_start), 0);
            chk("ready_while_busy", 32'((|req_ready) & uart_busy), 0);
            prev_start = uart_start;
        end
    end

    task automatic wait_ready(output logic [NR-1:0] r);
        bit got = 0;
        r = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                r   = req_ready;
                got = 1;
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_ready: no req_ready within 300 cycles");
        end
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 300 && quiet < 3; i++) begin
            @(negedge clk);
            if (!uart_busy && !uart_start) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: transmitter still busy after 300 cycles");
        end
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp);
        if (rx_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got no byte expected %0h", name, exp);
        end else begin
            chk(name, 32'(rx_q.pop_front()), 32'(exp));
        end
    endtask

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
        logic [2:0]  exp_id;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [NR-1:0] r;

        // rr_ptr walks 0 -> 3,0,1,2,3,0,2,1,0,2 through these single-byte grants.
        tbl[0] = '{4'b0100, 32'h13A5_1110, 3'd2, 8'hA5};
        tbl[1] = '{4'b1111, 32'h1312_1110, 3'd3, 8'h13};
        tbl[2] = '{4'b1111, 32'h1312_1110, 3'd0, 8'h10};
        tbl[3] = '{4'b1111, 32'h1312_1110, 3'd1, 8'h11};
        tbl[4] = '{4'b1111, 32'h1312_1110, 3'd2, 8'h12};
        tbl[5] = '{4'b1111, 32'h1312_1110, 3'd3, 8'h13};
        tbl[6] = '{4'b0110, 32'h1312_1110, 3'd1, 8'h11};
        tbl[7] = '{4'b0011, 32'h1312_1110, 3'd0, 8'h10};
        tbl[8] = '{4'b1001, 32'h1312_1110, 3'd3, 8'h13};
        tbl[9] = '{4'b1010, 32'h1312_1110, 3'd1, 8'h11};

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_start", 32'(uart_start), 0);
        chk("rst_data", 32'(uart_data), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err_timeout), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 10; n++) begin
            req_data  = tbl[n].data;
            req_last  = '1;
            req_valid = tbl[n].mask;
            wait_ready(r);
            chk($sformatf("v%0d_ready", n), 32'(r), 32'(4'b1 << tbl[n].exp_id));
            chk($sformatf("v%0d_grant", n), 32'(grant_id), 32'(tbl[n].exp_id));
            chk($sformatf("v%0d_locked", n), 32'(locked), 0);
            chk($sformatf("v%0d_start_early", n), 32'(uart_start), 0);
            req_valid = '0;
            @(negedge clk);
            chk($sformatf("v%0d_start", n), 32'(uart_start), 1);
            chk($sformatf("v%0d_data", n), 32'(uart_data), 32'(tbl[n].exp_byte));
            wait_idle();
            check_rx($sformatf("v%0d_rx", n), tbl[n].exp_byte);
        end

        // All four held valid for eight grants; rr_ptr starts at 2 here.
        req_data  = 32'h1312_1110;
        req_last  = '1;
        req_valid = '1;
        for (int g = 0; g < 8; g++) begin
            wait_ready(r);
            if (g == 7) req_valid = '0;
            chk($sformatf("rr%0d_ready", g), 32'(r), 32'(4'b1 << ((2 + g) % 4)));
            @(negedge clk);
            chk($sformatf("rr%0d_data", g), 32'(uart_data), 32'(8'h10 + (2 + g) % 4));
        end
        wait_idle();
        for (int g = 0; g < 8; g++) begin
            check_rx($sformatf("rr%0d_rx", g), 8'(8'h10 + (2 + g) % 4));
        end

        // Packet lock: req1 sends 41,42,43 while req0 waits with 30.
        req_last  = 4'b0000;
        req_data[15:8] = 8'h41;
        req_valid = 4'b0010;
        wait_ready(r);
        chk("pkt0_ready", 32'(r), 32'b0010);
        chk("pkt0_locked", 32'(locked), 1);
        req_data[7:0]  = 8'h30;
        req_data[15:8] = 8'h42;
        req_last  = 4'b0001;
        req_valid = 4'b0011;
        wait_ready(r);
        chk("pkt1_ready", 32'(r), 32'b0010);
        chk("pkt1_locked", 32'(locked), 1);
        req_data[15:8] = 8'h43;
        req_last  = 4'b0011;
        wait_ready(r);
        chk("pkt2_ready", 32'(r), 32'b0010);
        chk("pkt2_locked", 32'(locked), 0);
        req_valid = 4'b0001;
        wait_ready(r);
        chk("pkt3_ready", 32'(r), 32'b0001);
        chk("pkt3_grant", 32'(grant_id), 0);
        req_valid = '0;
        wait_idle();
        check_rx("pkt_rx0", 8'h41);
        check_rx("pkt_rx1", 8'h42);
        check_rx("pkt_rx2", 8'h43);
        check_rx("pkt_rx3", 8'h30);

        // Timeout: busy never rises; byte starts a packet so the lock must drop.
        tie_low = 1'b1;
        req_data[7:0] = 8'h55;
        req_last  = 4'b0000;
        req_valid = 4'b0001;
        wait_ready(r);
        req_valid = '0;
        chk("to_ready", 32'(r), 32'b0001);
        chk("to_locked_before", 32'(locked), 1);
        repeat (15) @(negedge clk);
        chk("to_err_early", 32'(err_timeout), 0);
        @(negedge clk);
        chk("to_err", 32'(err_timeout), 1);
        chk("to_locked_after", 32'(locked), 0);
        tie_low = 1'b0;
        req_data[7:0] = 8'h56;
        req_last  = 4'b1111;
        req_valid = 4'b0001;
        wait_ready(r);
        req_valid = '0;
        chk("to_next_ready", 32'(r), 32'b0001);
        wait_idle();
        check_rx("to_rx", 8'h56);
        chk("to_err_sticky", 32'(err_timeout), 1);

        // Reset in the middle of a locked packet from req3.
        req_data[31:24] = 8'h77;
        req_last  = 4'b0000;
        req_valid = 4'b1000;
        wait_ready(r);
        chk("mr_ready", 32'(r), 32'b1000);
        chk("mr_locked", 32'(locked), 1);
        repeat (22) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_rst_ready", 32'(req_ready), 0);
        chk("mr_rst_start", 32'(uart_start), 0);
        chk("mr_rst_data", 32'(uart_data), 0);
        chk("mr_rst_grant", 32'(grant_id), 0);
        chk("mr_rst_locked", 32'(locked), 0);
        chk("mr_rst_err", 32'(err_timeout), 0);
        @(negedge clk);
        rx_q.delete();
        req_data[15:8] = 8'h21;
        req_last  = 4'b1111;
        req_valid = 4'b1010;
        rst = 1'b0;
        wait_ready(r);
        req_valid = '0;
        chk("mr_first_ready", 32'(r), 32'b0010);
        wait_idle();
        check_rx("mr_rx", 8'h21);
        chk("mr_rx_empty", 32'(rx_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
